// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, data word, and the
// memory arbiter's grant state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins on contention unless a run of data grants has starved a
// waiting instruction fetch, in which case the fetch is forced through.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ram_err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state, next_state;
    logic [3:0] streak, next_streak;
    logic       d_pend;

    assign d_pend = dREN | dWEN;

    // Grant choice; 'starved' flips the D-wins-by-default rule.
    function automatic arb_state_t arbitrate(input logic i_p, input logic d_p,
                                             input logic starved);
        if (i_p && d_p) return starved ? IGRANT : DGRANT;
        if (d_p)        return DGRANT;
        if (i_p)        return IGRANT;
        return IDLE;
    endfunction

    // Grant register, starvation streak and sticky RAM error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            streak  <= '0;
            ram_err <= 1'b0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
            if (state != IDLE && ramstate == ERROR)
                ram_err <= 1'b1;
        end
    end

    // RAM steering, completion pulses and next grant. A completing
    // requester still holds its request this cycle, so it is left out
    // of the arbitration that picks the following grant.
    always_comb begin
        next_state  = state;
        next_streak = streak;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        unique case (state)
            IDLE: begin
                next_state = arbitrate(iREN, d_pend, streak == LIMIT);
            end
            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait       = 1'b0;
                        iload       = ramload;
                        next_streak = '0;
                        next_state  = arbitrate(1'b0, d_pend, streak == LIMIT);
                    end
                end
            end
            DGRANT: begin
                if (!d_pend) begin
                    next_state = IDLE;
                end else begin
                    // Write wins if both enables are (illegally) raised.
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == ACCESS) begin
                        dwait = 1'b0;
                        dload = ramload;
                        if (!iREN)
                            next_streak = '0;
                        else if (streak != LIMIT)
                            next_streak = streak + 4'd1;
                        next_state = arbitrate(iREN, 1'b0, streak == LIMIT);
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIM = 4;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t rs;
    logic      iwait, dwait, ramREN, ramWEN, ram_err;
    word_t     iload, dload, ramaddr, ramstore;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(rs),
        .ram_err(ram_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the RAM (0 none, 1 fetch, 2 data),
    // how many data grants in a row the fetch has waited through, error flag.
    int   m_owner, m_wait_run, n_owner, n_wait_run;
    logic m_err, n_err;
    logic  e_iwait, e_dwait, e_ren, e_wen;
    word_t e_iload, e_dload, e_addr, e_store;

    function automatic int pick(input bit iw, input bit dw, input int run);
        if (iw && dw) return (run >= LIM) ? 1 : 2;
        if (dw) return 2;
        if (iw) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input word_t got, input word_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Negedge: predict this cycle's outputs and the next model state.
    task automatic eval();
        bit dp;
        @(negedge CLK);
        dp = dREN | dWEN;
        e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
        n_owner = m_owner; n_wait_run = m_wait_run; n_err = m_err;
        if (m_owner == 0) begin
            n_owner = pick(iREN, dp, m_wait_run);
        end else if (m_owner == 1) begin
            if (!iREN) n_owner = 0;
            else begin
                e_ren = 1'b1; e_addr = iaddr;
                if (rs == ACCESS) begin
                    e_iwait = 1'b0; e_iload = ramload;
                    n_wait_run = 0;
                    n_owner = pick(1'b0, dp, m_wait_run);
                end
            end
        end else begin
            if (!dp) n_owner = 0;
            else begin
                e_wen = dWEN; e_ren = dREN && !dWEN;
                e_addr = daddr; e_store = dstore;
                if (rs == ACCESS) begin
                    e_dwait = 1'b0; e_dload = ramload;
                    n_wait_run = iREN ? ((m_wait_run + 1 > LIM) ? LIM : m_wait_run + 1) : 0;
                    n_owner = pick(iREN, 1'b0, m_wait_run);
                end
            end
        end
        if (m_owner != 0 && rs == ERROR) n_err = 1'b1;
        if (RST) begin n_owner = 0; n_wait_run = 0; n_err = 1'b0; end
        chk("iwait", iwait, e_iwait);
        chk("iload", iload, e_iload);
        chk("dwait", dwait, e_dwait);
        chk("dload", dload, e_dload);
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("ram_err", ram_err, m_err);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        m_owner = n_owner; m_wait_run = n_wait_run; m_err = n_err;
    endtask

    task automatic cyc();
        eval();
        tick();
    endtask

    bit i_done, d_done;
    int op;

    initial begin
        m_owner = 0; m_wait_run = 0; m_err = 1'b0;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; rs = FREE;
        @(posedge CLK); #1;
        // Reset state.
        eval();
        chk("rst_iwait", iwait, 1'b1); chk("rst_dwait", dwait, 1'b1);
        chk("rst_ren", ramREN, 1'b0);  chk("rst_wen", ramWEN, 1'b0);
        chk("rst_err", ram_err, 1'b0); chk("rst_addr", ramaddr, 32'h0);
        tick();
        RST = 1'b0;

        // Fetch at 0x0 with two BUSY cycles of latency.
        iREN = 1; iaddr = 32'h0;
        eval(); chk("t1_ren_t", ramREN, 1'b0); tick();
        rs = BUSY;
        eval(); chk("t1_ren_t1", ramREN, 1'b1); chk("t1_iwait_t1", iwait, 1'b1); tick();
        cyc();
        rs = ACCESS; ramload = 32'h8C010004;
        eval(); chk("t1_iwait_t3", iwait, 1'b0); chk("t1_iload", iload, 32'h8C010004); tick();
        iREN = 0; rs = FREE;
        cyc();

        // Simultaneous requests: data first, fetch immediately after.
        iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h100;
        cyc();
        rs = ACCESS; ramload = 32'h11111111;
        eval();
        chk("t2_daddr", ramaddr, 32'h100); chk("t2_dwait", dwait, 1'b0);
        chk("t2_dload", dload, 32'h11111111);
        tick();
        dREN = 0; ramload = 32'h22222222;
        eval(); chk("t2_iaddr", ramaddr, 32'h40); chk("t2_ren", ramREN, 1'b1);
        chk("t2_iwait", iwait, 1'b0);
        tick();
        iREN = 0; rs = FREE;
        cyc();

        // Continuous write traffic alongside a waiting fetch.
        dWEN = 1; dstore = 32'h55; daddr = 32'h200; iREN = 1; iaddr = 32'h80; rs = ACCESS;
        repeat (6) cyc();
        dWEN = 0; iREN = 0; rs = FREE;
        cyc(); cyc();

        // Build a starved fetch: four data completions while the fetch
        // waits, the fetch backing off each time before it is served.
        RST = 1; cyc(); RST = 0;
        for (int k = 0; k < LIM; k++) begin
            iREN = 1; dWEN = 1; iaddr = 32'h300; daddr = 32'h400; rs = FREE;
            cyc();
            rs = ACCESS; cyc();
            iREN = 0; dWEN = 0; rs = FREE; cyc();
        end
        iREN = 1; dWEN = 1;
        cyc();
        rs = ACCESS;
        eval(); chk("starve_ren", ramREN, 1'b1); chk("starve_wen", ramWEN, 1'b0);
        chk("starve_addr", ramaddr, 32'h300); chk("starve_iwait", iwait, 1'b0);
        tick();
        iREN = 0;
        eval(); chk("after_starve_wen", ramWEN, 1'b1); chk("after_starve_addr", ramaddr, 32'h400);
        tick();
        dWEN = 0; rs = FREE;
        cyc();

        // Read and write raised together: the write wins.
        dREN = 1; dWEN = 1; dstore = 32'hDEADBEEF; daddr = 32'h500;
        cyc();
        rs = BUSY;
        eval(); chk("rw_wen", ramWEN, 1'b1); chk("rw_ren", ramREN, 1'b0);
        chk("rw_store", ramstore, 32'hDEADBEEF);
        tick();
        rs = ACCESS; cyc();
        dREN = 0; dWEN = 0; rs = FREE; cyc();

        // One ERROR cycle inside a data grant, then retry to completion.
        dREN = 1; daddr = 32'h600;
        cyc();
        rs = ERROR;
        eval(); chk("err_dwait", dwait, 1'b1); tick();
        rs = BUSY;
        eval(); chk("err_sticky", ram_err, 1'b1); chk("err_dwait2", dwait, 1'b1); tick();
        rs = ACCESS; ramload = 32'h77;
        eval(); chk("err_done", dwait, 1'b0); chk("err_dload", dload, 32'h77);
        chk("err_sticky2", ram_err, 1'b1);
        tick();
        dREN = 0; rs = FREE; cyc();

        // Reset while a data grant is waiting on BUSY.
        dREN = 1; daddr = 32'h700;
        cyc();
        rs = BUSY; cyc();
        RST = 1;
        eval(); chk("rst_mid_ren", ramREN, 1'b1); tick();
        RST = 0;
        eval(); chk("rst_mid_ren2", ramREN, 1'b0); chk("rst_mid_dwait", dwait, 1'b1);
        chk("rst_mid_err", ram_err, 1'b0); chk("rst_mid_addr", ramaddr, 32'h0);
        tick();
        dREN = 0; rs = FREE; cyc();

        // Random traffic: requesters hold until served, sometimes abort.
        i_done = 0; d_done = 0;
        for (int n = 0; n < 600; n++) begin
            if (!iREN) begin
                if ($urandom_range(0, 2) == 0) begin iREN = 1; iaddr = $urandom; end
            end else if (i_done) begin
                iREN = 1'($urandom_range(0, 1)); iaddr = $urandom;
            end else if ($urandom_range(0, 19) == 0) iREN = 0;
            if (!(dREN | dWEN) || d_done) begin
                if ($urandom_range(0, 1) == 0) begin
                    op = $urandom_range(0, 19);
                    dREN = (op < 10) || (op == 19);
                    dWEN = (op >= 10);
                    daddr = $urandom; dstore = $urandom;
                end else begin
                    dREN = 0; dWEN = 0;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                dREN = 0; dWEN = 0;
            end
            op = $urandom_range(0, 9);
            rs = (op < 2) ? FREE : (op < 6) ? BUSY : (op < 9) ? ACCESS : ERROR;
            ramload = $urandom;
            RST = ($urandom_range(0, 49) == 0);
            eval();
            i_done = !e_iwait;
            d_done = !e_dwait;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
